mem_bist: RTL and testbench



---
 rtl/mem_bist.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bist.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist
// Brief    : Built-in self-test initiator for a small register-file memory.
//            Writes pattern(a) = zext(a) ^ SEED to every location, reads
//            every location back, and reports pass/fail, a saturating
//            error count and the first failing address.
// Options  : define BIST_INV_PASS_EN to follow the first pass with a second
//            WRITE/READ/DRAIN pass using ~pattern(a).
// Revision : 1.0 - initial release
// ============================================================================
module mem_bist #(
    parameter int              DEPTH = 11,
    parameter int              AW    = 4,
    parameter int              DW    = 8,
    parameter logic [DW-1:0]   SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               wr,
    output logic               rd,
    output logic [AW-1:0]      addr,
    output logic [DW-1:0]      Datain,
    input  logic [DW-1:0]      Dataout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [3:0]         err_count,
    output logic [AW-1:0]      fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] datain_q, datain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [3:0]    err_count_q, err_count_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [AW-1:0] prev_addr_q, prev_addr_d;

    logic [DW-1:0] w_flip;
    logic          w_last_pass;
    logic          w_cmp_en;
    logic          w_mismatch;
    logic [3:0]    w_err_upd;
    logic [AW-1:0] w_fail_upd;
    logic [AW-1:0] w_addr_inc;

    // Base test pattern: address zero-extended to data width, keyed by SEED.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return DW'(a) ^ SEED;
    endfunction

`ifdef BIST_INV_PASS_EN
    logic inv_q, inv_d;
    // The second pass stores and expects the complement of the base pattern.
    assign w_flip      = {DW{inv_q}};
    assign w_last_pass = inv_q;
`else
    assign w_flip      = '0;
    assign w_last_pass = 1'b1;
`endif

    assign w_addr_inc = addr_q + AW'(1);

    // Read data lags the address by one cycle, so the first READ cycle has
    // nothing to compare and DRAIN compares the final location.
    assign w_cmp_en   = ((state_q == S_READ) && (addr_q != '0)) || (state_q == S_DRAIN);
    assign w_mismatch = w_cmp_en && (Dataout != (pattern(prev_addr_q) ^ w_flip));

    // Saturating error counter and first-failure address capture.
    always_comb begin
        w_err_upd  = err_count_q;
        w_fail_upd = fail_addr_q;
        if (w_mismatch) begin
            if (err_count_q != 4'd15) begin
                w_err_upd = err_count_q + 4'd1;
            end
            if (err_count_q == 4'd0) begin
                w_fail_upd = prev_addr_q;
            end
        end
    end

    // Next-state and next-output computation for the test sequencer.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        datain_d    = datain_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = w_err_upd;
        fail_addr_d = w_fail_upd;
        prev_addr_d = addr_q;
`ifdef BIST_INV_PASS_EN
        inv_d       = inv_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    wr_d        = 1'b1;
                    rd_d        = 1'b0;
                    addr_d      = '0;
                    datain_d    = pattern('0);
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = 4'd0;
                    fail_addr_d = '0;
`ifdef BIST_INV_PASS_EN
                    inv_d       = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d  = S_READ;
                    wr_d     = 1'b0;
                    rd_d     = 1'b1;
                    addr_d   = '0;
                    datain_d = '0;
                end else begin
                    addr_d   = w_addr_inc;
                    datain_d = pattern(w_addr_inc) ^ w_flip;
                end
            end
            S_READ: begin
                // On the last address rd stays high and addr holds for DRAIN.
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = w_addr_inc;
                end
            end
            S_DRAIN: begin
                if (!w_last_pass) begin
                    state_d  = S_WRITE;
                    wr_d     = 1'b1;
                    rd_d     = 1'b0;
                    addr_d   = '0;
                    datain_d = ~pattern('0);
`ifdef BIST_INV_PASS_EN
                    inv_d    = 1'b1;
`endif
                end else begin
                    state_d = S_DONE;
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (w_err_upd == 4'd0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and aborts a test.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            datain_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 4'd0;
            fail_addr_q <= '0;
            prev_addr_q <= '0;
`ifdef BIST_INV_PASS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            datain_q    <= datain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_addr_q <= fail_addr_d;
            prev_addr_q <= prev_addr_d;
`ifdef BIST_INV_PASS_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign Datain    = datain_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_addr = fail_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_bist
// Brief    : Self-checking bench for mem_bist with a fault-injecting memory
//            model and a reference model of the expected test outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bist;

    localparam int          DEPTH = 11;
    localparam int          AW    = 4;
    localparam int          DW    = 8;
    localparam logic [7:0]  SEED  = 8'hA5;
`ifdef BIST_INV_PASS_EN
    localparam int          NPASS = 2;
`else
    localparam int          NPASS = 1;
`endif
    localparam int          LAT   = NPASS * (2 * DEPTH + 1) + 1;
    localparam int          LAT16 = NPASS * (2 * 16 + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start16 = 1'b0;

    logic          wr, rd, busy, done, pass;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] Datain, Dataout;
    logic [3:0]    err_count;

    logic          wr16, rd16, busy16, done16, pass16;
    logic [AW-1:0] addr16, fail_addr16;
    logic [DW-1:0] Datain16, Dataout16;
    logic [3:0]    err_count16;

    // Memory model state and fault injection controls.
    logic [7:0] mem   [0:15];
    logic [7:0] mem16 [0:15];
    logic [7:0] s1    [0:15];
    logic [7:0] s0    [0:15];
    logic       read_ff = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic [7:0] rdata16 = 8'h00;

    logic [3:0] wa [$];
    logic [7:0] wd [$];
    int         both_hi = 0;

    int checks = 0;
    int errors = 0;

    mem_bist dut (
        .clk(clk), .rst(rst), .start(start),
        .wr(wr), .rd(rd), .addr(addr), .Datain(Datain), .Dataout(Dataout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    mem_bist #(.DEPTH(16), .AW(4), .DW(8), .SEED(8'hA5)) dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .wr(wr16), .rd(rd16), .addr(addr16), .Datain(Datain16), .Dataout(Dataout16),
        .busy(busy16), .done(done16), .pass(pass16),
        .err_count(err_count16), .fail_addr(fail_addr16)
    );

    initial forever #5 clk = ~clk;

    // Main memory: stuck-at faults applied on write, optional all-0xFF reads.
    always @(posedge clk) begin
        if (wr) mem[addr] <= (Datain | s1[addr]) & ~s0[addr];
        if (rd) rdata <= read_ff ? 8'hFF : mem[addr];
    end
    assign Dataout = rdata;

    // 16-deep memory returns the complement of what was stored: every read wrong.
    always @(posedge clk) begin
        if (wr16) mem16[addr16] <= Datain16;
        if (rd16) rdata16 <= ~mem16[addr16];
    end
    assign Dataout16 = rdata16;

    // Record the write stream and watch for simultaneous strobes.
    always @(negedge clk) begin
        if (wr) begin
            wa.push_back(addr);
            wd.push_back(Datain);
        end
        if (wr && rd) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 16; a++) begin
            s1[a] = 8'h00;
            s0[a] = 8'h00;
        end
        read_ff = 1'b0;
    endtask

    // Reference outcome: walk every pass and location in test order.
    function automatic void model(output int e, output int fa);
        int         cnt;
        logic [7:0] ev;
        logic [7:0] got;
        cnt = 0;
        fa  = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                ev  = 8'(a) ^ SEED;
                if (p == 1) ev = ~ev;
                got = read_ff ? 8'hFF : ((ev | s1[a]) & ~s0[a]);
                if (got != ev) begin
                    if (cnt == 0) fa = a;
                    cnt++;
                end
            end
        end
        e = (cnt > 15) ? 15 : cnt;
    endfunction

    task automatic run_bist(input string tag, input int repulse_at);
        int         cyc;
        int         busy_gap;
        int         e;
        int         fa;
        int         bad;
        int         ia;
        logic [7:0] ev;
        wa.delete();
        wd.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        check({tag, ".done_clear"}, 32'(done), 32'd0);
        busy_gap = 0;
        while (!done && cyc < 400) begin
            start = (cyc == repulse_at);
            @(negedge clk);
            cyc++;
            if (!done && !busy) busy_gap++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(cyc), 32'(LAT));
        check({tag, ".busy_gap"}, 32'(busy_gap), 32'd0);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check({tag, ".strobes_end"}, 32'({wr, rd}), 32'd0);
        model(e, fa);
        check({tag, ".err_count"}, 32'(err_count), 32'(e));
        check({tag, ".fail_addr"}, 32'(fail_addr), 32'(fa));
        check({tag, ".pass"}, 32'(pass), 32'(e == 0));
        check({tag, ".nwrites"}, 32'(wa.size()), 32'(NPASS * DEPTH));
        bad = 0;
        for (int i = 0; i < wa.size(); i++) begin
            ia = i % DEPTH;
            ev = 8'(ia) ^ SEED;
            if (i >= DEPTH) ev = ~ev;
            if (wa[i] != 4'(ia) || wd[i] != ev) bad++;
        end
        check({tag, ".write_seq"}, 32'(bad), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr"}, 32'(wr), 32'd0);
        check({tag, ".rd"}, 32'(rd), 32'd0);
        check({tag, ".addr"}, 32'(addr), 32'd0);
        check({tag, ".Datain"}, 32'(Datain), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'd0);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
        check({tag, ".fail_addr"}, 32'(fail_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cyc;
        int         nf;
        int         fa;
        int         fb;
        logic [7:0] v;

        for (int a = 0; a < 16; a++) begin
            mem[a]   = 8'h00;
            mem16[a] = 8'h00;
        end
        clear_faults();

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset.busy16", 32'(busy16), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean run with an ideal memory.
        run_bist("clean", 0);
        check("clean.err_const", 32'(err_count), 32'd0);
        check("clean.pass_const", 32'(pass), 32'd1);
        v = (wd.size() > 3) ? wd[3] : 8'h00;
        check("clean.wdata_a3", 32'(v), 32'h0A6);
`ifdef BIST_INV_PASS_EN
        v = (wd.size() > DEPTH + 3) ? wd[DEPTH + 3] : 8'h00;
        check("clean.wdata_inv_a3", 32'(v), 32'h059);
`endif

        // Done outputs hold while idle.
        repeat (3) @(negedge clk);
        check("hold.done", 32'(done), 32'd1);
        check("hold.pass", 32'(pass), 32'd1);

        // Address 5 bit 0 stuck at 1.
        clear_faults();
        s1[5] = 8'h01;
        run_bist("sa1_a5b0", 0);
        check("sa1_a5b0.err_const", 32'(err_count), 32'd1);
        check("sa1_a5b0.fail_const", 32'(fail_addr), 32'd5);

        // Every read returns 0xFF; then reset and repeat.
        clear_faults();
        read_ff = 1'b1;
        run_bist("ff", 0);
`ifdef BIST_INV_PASS_EN
        check("ff.err_const", 32'(err_count), 32'd15);
`else
        check("ff.err_const", 32'(err_count), 32'd11);
`endif
        check("ff.fail_const", 32'(fail_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("ff_rst");
        rst = 1'b0;
        @(negedge clk);
        run_bist("ff_again", 0);
`ifdef BIST_INV_PASS_EN
        check("ff_again.err_const", 32'(err_count), 32'd15);
`else
        check("ff_again.err_const", 32'(err_count), 32'd11);
`endif

        // Address 2 bit 7 stuck at 1: only visible to the inverted pass.
        clear_faults();
        s1[2] = 8'h80;
        run_bist("sa1_a2b7", 0);
`ifdef BIST_INV_PASS_EN
        check("sa1_a2b7.err_const", 32'(err_count), 32'd1);
        check("sa1_a2b7.fail_const", 32'(fail_addr), 32'd2);
`else
        check("sa1_a2b7.err_const", 32'(err_count), 32'd0);
`endif

        // Saturation on the 16-deep instance with every read wrong.
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("d16.latency", 32'(cyc), 32'(LAT16));
        check("d16.err_count", 32'(err_count16), 32'd15);
        check("d16.fail_addr", 32'(fail_addr16), 32'd0);
        check("d16.pass", 32'(pass16), 32'd0);

        // Reset during the 4th READ cycle aborts the test.
        clear_faults();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < DEPTH + 4) begin
            @(negedge clk);
            cyc++;
        end
        check("abort.in_read", 32'(rd), 32'd1);
        check("abort.read_addr", 32'(addr), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        @(negedge clk);
        check("abort.idle", 32'(busy), 32'd0);
        run_bist("after_abort", 0);
        check("after_abort.pass_const", 32'(pass), 32'd1);

        // start re-pulsed mid-WRITE is ignored.
        run_bist("repulse", 5);

        // Randomized stuck-at faults.
        for (int it = 0; it < 8; it++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) begin
                fa = $urandom_range(0, DEPTH - 1);
                fb = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) s1[fa] = s1[fa] | (8'h01 << fb);
                else                           s0[fa] = s0[fa] | (8'h01 << fb);
            end
            run_bist($sformatf("rand%0d", it), 0);
        end

        check("strobe_exclusive", 32'(both_hi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
